tetris_line_clear: RTL

- Parametrised line-clear engine for the Tetris board stored in on-chip SRAM. It runs after a piece locks.
- Scans rows bottom-up and detects full rows. Shifts every row above each full row down by one and blanks row 0.
- Reports the number of lines cleared. The game controller owns the SRAM port while this block is idle and hands it over with `start`.

---
 rtl/tetris_line_clear_if.sv | 45 ++++
 rtl/tetris_line_clear.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tetris_line_clear_if.sv
// -----------------------------------------------------------------------------
// tetris_line_clear_if
// Single-port board SRAM bus shared between the line-clear engine and the
// board memory.
//
// Signals:
//   mem_x      column address           (engine -> memory)
//   mem_y      row address              (engine -> memory)
//   mem_re     read strobe, data next cycle
//   mem_we     write strobe, same-cycle write
//   mem_wdata  write data
//   mem_rdata  read data, one-cycle latency (memory -> engine)
//
// Modports: master = engine side, slave = memory side.
// -----------------------------------------------------------------------------
interface tetris_line_clear_if #(
    parameter int XW      = 4,
    parameter int YW      = 5,
    parameter int COLOR_W = 3
);
    logic [XW-1:0]      mem_x;
    logic [YW-1:0]      mem_y;
    logic               mem_re;
    logic               mem_we;
    logic [COLOR_W-1:0] mem_wdata;
    logic [COLOR_W-1:0] mem_rdata;

    modport master (
        output mem_x,
        output mem_y,
        output mem_re,
        output mem_we,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_x,
        input  mem_y,
        input  mem_re,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/tetris_line_clear.sv
// -----------------------------------------------------------------------------
// tetris_line_clear
// Line-clear engine for a Tetris board held in single-port SRAM. After a piece
// locks, the game controller pulses start and hands over the SRAM port. Rows
// are scanned bottom-up; each full row is removed by copying every row above
// it down by one and blanking row 0. The row that moves into the cleared slot
// is re-checked, so stacked full rows are all removed.
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-high reset
//   start          scan request, ignored unless idle
//   busy           high whenever not idle (includes the done cycle)
//   done           one-cycle completion pulse
//   lines_cleared  rows removed by the last scan, saturating at 7
//   total_lines    rows removed since reset, saturating at 16'hFFFF
//   mem            board SRAM bus (master side)
//
// State table:
//   IDLE    | waiting for start; controller owns the SRAM
//   CHK_RD  | read cell (x, y) of the row under test
//   CHK_EV  | evaluate read data; advance column, row, or start a clear
//   SH_RD   | read cell (x, sy-1) of the row above the destination
//   SH_WR   | write that cell into (x, sy)
//   CLR_TOP | write EMPTY_COLOR into (x, 0), count the line when done
//   DONE    | one-cycle done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module tetris_line_clear #(
    parameter int BOARD_W     = 10,
    parameter int BOARD_H     = 20,
    parameter int COLOR_W     = 3,
    parameter int EMPTY_COLOR = 7,
    parameter int XW          = $clog2(BOARD_W),
    parameter int YW          = $clog2(BOARD_H)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           lines_cleared,
    output logic [15:0]          total_lines,
    tetris_line_clear_if.master  mem
);

    localparam logic [XW-1:0]      X_LAST = XW'(BOARD_W - 1);
    localparam logic [YW-1:0]      Y_TOP  = YW'(BOARD_H - 1);
    localparam logic [COLOR_W-1:0] EMPTY  = COLOR_W'(EMPTY_COLOR);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHK_RD  = 3'd1,
        CHK_EV  = 3'd2,
        SH_RD   = 3'd3,
        SH_WR   = 3'd4,
        CLR_TOP = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t        state, state_n;
    logic [XW-1:0] x, x_n;
    logic [YW-1:0] y, y_n;
    logic [YW-1:0] sy, sy_n;
    logic [2:0]    lc_n;
    logic [15:0]   tl_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            x             <= '0;
            y             <= '0;
            sy            <= '0;
            lines_cleared <= '0;
            total_lines   <= '0;
        end else begin
            state         <= state_n;
            x             <= x_n;
            y             <= y_n;
            sy            <= sy_n;
            lines_cleared <= lc_n;
            total_lines   <= tl_n;
        end
    end

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        sy_n    = sy;
        lc_n    = lines_cleared;
        tl_n    = total_lines;

        case (state)
            IDLE: begin
                if (start) begin
                    y_n     = Y_TOP;
                    x_n     = '0;
                    lc_n    = '0;
                    state_n = CHK_RD;
                end
            end

            CHK_RD: state_n = CHK_EV;

            CHK_EV: begin
                if (mem.mem_rdata == EMPTY) begin
                    x_n = '0;
                    if (y == '0) begin
                        state_n = DONE;
                    end else begin
                        y_n     = y - YW'(1);
                        state_n = CHK_RD;
                    end
                end else if (x != X_LAST) begin
                    x_n     = x + XW'(1);
                    state_n = CHK_RD;
                end else begin
                    sy_n    = y;
                    x_n     = '0;
                    state_n = (y == '0) ? CLR_TOP : SH_RD;
                end
            end

            SH_RD: state_n = SH_WR;

            SH_WR: begin
                if (x != X_LAST) begin
                    x_n     = x + XW'(1);
                    state_n = SH_RD;
                end else begin
                    x_n = '0;
                    if (sy == YW'(1)) begin
                        state_n = CLR_TOP;
                    end else begin
                        sy_n    = sy - YW'(1);
                        state_n = SH_RD;
                    end
                end
            end

            CLR_TOP: begin
                if (x != X_LAST) begin
                    x_n = x + XW'(1);
                end else begin
                    x_n = '0;
                    if (lines_cleared != 3'd7)
                        lc_n = lines_cleared + 3'd1;
                    if (total_lines != 16'hFFFF)
                        tl_n = total_lines + 16'd1;
                    // y is left alone: the row just shifted into y is re-checked.
                    state_n = CHK_RD;
                end
            end

            DONE: state_n = IDLE;

            default: state_n = IDLE;
        endcase
    end

    // SRAM strobes and addresses are decoded from registered state only.
    // In SH_WR the write data is the SRAM's own read data from the SH_RD
    // cycle, passed straight back so a shifted cell costs two cycles.
    always_comb begin
        busy          = (state != IDLE);
        done          = (state == DONE);
        mem.mem_re    = (state == CHK_RD) || (state == SH_RD);
        mem.mem_we    = (state == SH_WR) || (state == CLR_TOP);
        mem.mem_x     = x;
        mem.mem_y     = '0;
        mem.mem_wdata = '0;
        case (state)
            CHK_RD, CHK_EV: mem.mem_y = y;
            SH_RD:          mem.mem_y = sy - YW'(1);
            SH_WR: begin
                mem.mem_y     = sy;
                mem.mem_wdata = mem.mem_rdata;
            end
            CLR_TOP:        mem.mem_wdata = EMPTY;
            default:        mem.mem_y = '0;
        endcase
    end

endmodule
